lb_btn_event: RTL and testbench
===============================

// Module: lb_btn_event
// PURPOSE
//  Consumes the debounced button level and turns it into single-cycle press/release
//  strobes, a wrapping press counter and a PicoBlaze-style interrupt request.
//  The request is held until acknowledged and carries an event code.
//  Sits between the button debouncer and the PicoBlaze interrupt/input-port logic.
// PARAMETERS
//  CNT_W      8        width of press counter
//  TICK_DIV   1000000  clk cycles per hold-timer tick (10 ms at 100 MHz)
//  TICK_W     20       prescaler width; must satisfy 2^TICK_W >= TICK_DIV
//  LONG_TICKS 100      ticks db must stay high before long-press event (1 s)
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-low reset
//  db         in   1      debounced button level, synchronous to clk
//  int_ack    in   1      interrupt acknowledge from processor, 1-cycle pulse
//  clr        in   1      synchronous clear of press_cnt and overrun
//  press_pulse   out 1      one-cycle strobe on db 0->1
//  release_pulse out 1      one-cycle strobe on db 1->0
//  interrupt  out  1      interrupt request, level, held until int_ack
//  event_code out  2      cause of pending request: 01 press, 10 release, 11 long
//  press_cnt  out  CNT_W  number of presses, modulo 2^CNT_W
//  overrun    out  1      sticky: an event was dropped while a request was pending
// BEHAVIOUR
//  - Reset: all outputs 0, hold FSM IDLE, prescaler and hold timer 0, db_q 0.
//  - Edge detect: db_q <= db. press_pulse <= db & ~db_q; release_pulse <= ~db & db_q.
//    Both are registered, high for exactly 1 cycle. Each fires one cycle after the
//    first clk edge sampling the new db level.
//  - press_cnt: +1 in the cycle press_pulse rises; wraps 2^CNT_W-1 -> 0.
//    clr has priority: clr together with a press gives 0.
//  - Hold FSM: IDLE -(press)-> PRESSED -(hold_cnt==LONG_TICKS)-> HELD.
//    PRESSED/HELD -(release)-> IDLE. HELD is left only by release.
//  - Hold timer counts prescaler ticks while PRESSED and is zeroed on entry to PRESSED.
//    Prescaler free-runs 0..TICK_DIV-1; a tick occurs at wrap.
//    Long-event latency after press is therefore LONG_TICKS-1..LONG_TICKS ticks.
//  - Event priority within a cycle: release > long > press (press and release never coincide).
//  - Interrupt handshake, new event E in a cycle:
//      interrupt=0                  -> interrupt<=1, event_code<=E next cycle.
//      interrupt=1, int_ack=1       -> event_code<=E, interrupt stays 1.
//      interrupt=1, int_ack=0       -> E dropped, overrun<=1, event_code unchanged.
//    No event and int_ack=1 -> interrupt<=0 next cycle; event_code keeps its last value.
//    int_ack while interrupt=0 is ignored.
//  - overrun: cleared only by clr or reset. clr does not touch interrupt or event_code.
//  - Reset mid-hold or mid-request: everything returns to the reset state; no event is emitted.
// CONFIGURATION
//  LB_BTN_LONG_PRESS_EN defined:
//    prescaler, hold timer and HELD state are built; code 11 is generated.
//  Not defined:
//    no prescaler or timer; FSM is IDLE/PRESSED only; code 11 is never produced.
//    TICK_DIV, TICK_W and LONG_TICKS are ignored.
// STRUCTURE
//  - lb_pkg: EV_NONE/EV_PRESS/EV_RELEASE/EV_LONG 2-bit localparams and
//    hold-FSM state encodings (IDLE, PRESSED, HELD).
//  - Sub-module lb_tick_gen (parameters TICK_DIV, TICK_W): free-running prescaler,
//    one-cycle tick output. Reusable by the debouncer.
// TESTING  (TICK_DIV=4, LONG_TICKS=3, CNT_W=3, macro defined unless noted)
//  1. Reset released, db=0 for 20 cycles -> all outputs 0, interrupt never rises.
//  2. db 0->1 at edge k -> press_pulse=1 only in cycle k+1; interrupt=1 and
//     event_code=01 from k+1; int_ack pulse -> interrupt=0 the next cycle.
//  3. db held 1 for 20 cycles with acks -> exactly one code 11 between 8 and 12 cycles
//     after press; release -> code 10.
//  4. Press then release without int_ack -> event_code stays 01, overrun=1;
//     clr -> overrun=0, press_cnt=0.
//  5. 9 press/release pairs, each acked -> press_cnt=1 (wrap at 8).
//     Press and clr in the same cycle -> press_cnt=0.
//  6. Reset asserted while in HELD with interrupt=1 -> next cycle all outputs 0.
//     Rebuilt without the macro, 40-cycle hold -> never produces code 11.

Source files
------------

// File: rtl/lb_pkg.sv
// Shared event codes and hold-FSM encodings for the button event block.
// Imported by lb_tick_gen and lb_btn_event.
package lb_pkg;

  localparam logic [1:0] EV_NONE    = 2'b00;
  localparam logic [1:0] EV_PRESS   = 2'b01;
  localparam logic [1:0] EV_RELEASE = 2'b10;
  localparam logic [1:0] EV_LONG    = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESSED = 2'b01,
    HELD    = 2'b10
  } hold_st_t;

endpackage

// File: rtl/lb_tick_gen.sv
// Free-running prescaler 0..TICK_DIV-1, one-cycle tick at wrap.
// Ports: clk, reset (async, active-low), tick (out).
module lb_tick_gen
  import lb_pkg::*;
#(
  parameter int TICK_DIV = 1000000,
  parameter int TICK_W   = 20
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/lb_btn_event.sv
// Button level -> press/release strobes, press counter, held interrupt
// request with event code. Long press built only with LB_BTN_LONG_PRESS_EN.
// Ports: clk, reset (async low), db, int_ack, clr in; press_pulse,
// release_pulse, interrupt, event_code[1:0], press_cnt, overrun out.
module lb_btn_event
  import lb_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int TICK_DIV   = 1000000,
  parameter int TICK_W     = 20,
  parameter int LONG_TICKS = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             db,
  input  logic             int_ack,
  input  logic             clr,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             interrupt,
  output logic [1:0]       event_code,
  output logic [CNT_W-1:0] press_cnt,
  output logic             overrun
);

  logic       db_q;
  logic       rise;
  logic       fall;
  logic       long_ev;
  logic [1:0] ev;
  hold_st_t   state;

  assign rise = db & ~db_q;
  assign fall = ~db & db_q;

`ifdef LB_BTN_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);

  logic          tick;
  logic [HW-1:0] hold_cnt;

  lb_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .TICK_W   (TICK_W)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Fires on the edge where the timer reaches LONG_TICKS.
  assign long_ev = (state == PRESSED) && !fall
                && tick && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rise) begin
            state    <= PRESSED;
            hold_cnt <= '0;
          end
        end
        PRESSED: begin
          if (fall) begin
            state <= IDLE;
          end else if (long_ev) begin
            state <= HELD;
          end else if (tick) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        HELD: begin
          if (fall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  localparam int unused_cfg = TICK_DIV + TICK_W + LONG_TICKS;

  assign long_ev = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (rise) state <= PRESSED;
        PRESSED: if (fall) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`endif

  // release > long > press
  always_comb begin
    ev = EV_NONE;
    unique case (1'b1)
      fall:    ev = EV_RELEASE;
      long_ev: ev = EV_LONG;
      rise:    ev = EV_PRESS;
      default: ev = EV_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_q          <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      interrupt     <= 1'b0;
      event_code    <= EV_NONE;
      press_cnt     <= '0;
      overrun       <= 1'b0;
    end else begin
      db_q          <= db;
      press_pulse   <= rise;
      release_pulse <= fall;

      if (clr) begin
        press_cnt <= '0;
      end else if (rise) begin
        press_cnt <= press_cnt + 1'b1;
      end

      if (ev != EV_NONE) begin
        if (!interrupt || int_ack) begin
          interrupt  <= 1'b1;
          event_code <= ev;
        end else begin
          overrun <= 1'b1;
        end
      end else if (int_ack) begin
        interrupt <= 1'b0;
      end

      // clr wins over a drop in the same cycle
      if (clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lb_btn_event.sv
// Directed bench for lb_btn_event (CNT_W=3, TICK_DIV=4, LONG_TICKS=3).
// Long-press checks follow LB_BTN_LONG_PRESS_EN.
module tb_lb_btn_event;
  import lb_pkg::*;

  logic       clk;
  logic       reset;
  logic       db;
  logic       int_ack;
  logic       clr;
  logic       press_pulse;
  logic       release_pulse;
  logic       interrupt;
  logic [1:0] event_code;
  logic [2:0] press_cnt;
  logic       overrun;

  int n_vec = 0;
  int n_err = 0;

  lb_btn_event #(
    .CNT_W      (3),
    .TICK_DIV   (4),
    .TICK_W     (2),
    .LONG_TICKS (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .db            (db),
    .int_ack       (int_ack),
    .clr           (clr),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .interrupt     (interrupt),
    .event_code    (event_code),
    .press_cnt     (press_cnt),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {23'd0, press_pulse, release_pulse, interrupt,
            event_code, press_cnt, overrun};
  endfunction

  initial begin
    logic seen;
    int   nint;
    int   nlong;
    int   at;

    reset = 1'b0;
    db = 1'b0;
    int_ack = 1'b0;
    clr = 1'b0;
    step();
    step();
    chk("rst_outs", outs(), 32'd0);
    reset = 1'b1;

    // 1: idle
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (outs() != 32'd0) seen = 1'b1;
    end
    chk("idle_quiet", {31'd0, seen}, 32'd0);

    // 2: press, ack
    db = 1'b1;
    step();
    chk("press_pulse", {31'd0, press_pulse}, 32'd1);
    chk("press_int", {31'd0, interrupt}, 32'd1);
    chk("press_code", {30'd0, event_code}, {30'd0, EV_PRESS});
    chk("press_cnt1", {29'd0, press_cnt}, 32'd1);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("press_pulse_1cyc", {31'd0, press_pulse}, 32'd0);
    chk("ack_drop", {31'd0, interrupt}, 32'd0);

    // 3: long hold, acking each request
    nint = 0;
    nlong = 0;
    at = 0;
    for (int i = 2; i < 42; i++) begin
      step();
      int_ack = 1'b0;
      if (interrupt) begin
        nint++;
        if (event_code == EV_LONG) begin
          nlong++;
          at = i;
        end
        int_ack = 1'b1;
      end
    end
    int_ack = 1'b0;
`ifdef LB_BTN_LONG_PRESS_EN
    chk("long_once", nlong, 32'd1);
    chk("long_only", nint, 32'd1);
    chk("long_win", {31'd0, (at >= 8 && at <= 12)}, 32'd1);
`else
    chk("no_long", nlong, 32'd0);
    chk("hold_quiet", nint, 32'd0);
`endif
    db = 1'b0;
    step();
    chk("rel_pulse", {31'd0, release_pulse}, 32'd1);
    chk("rel_code", {29'd0, interrupt, event_code}, 32'b110);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("rel_ack", {30'd0, interrupt, release_pulse}, 32'd0);

    // 4: overrun
    db = 1'b1;
    step();
    chk("p2_cnt", {29'd0, press_cnt}, 32'd2);
    db = 1'b0;
    step();
    chk("ovr_code", {29'd0, interrupt, event_code}, 32'b101);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_outs", {27'd0, interrupt, event_code, overrun, press_cnt == 3'd0},
        32'b10101);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;

    // 5: wrap
    for (int i = 0; i < 9; i++) begin
      db = 1'b1;
      step();
      int_ack = 1'b1;
      step();
      db = 1'b0;
      int_ack = 1'b0;
      step();
      int_ack = 1'b1;
      step();
      int_ack = 1'b0;
    end
    chk("wrap_cnt", {29'd0, press_cnt}, 32'd1);
    chk("wrap_quiet", {30'd0, interrupt, overrun}, 32'd0);
    db = 1'b1;
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_press", {27'd0, press_pulse, interrupt, press_cnt}, 32'b11000);

    // 6: reset mid-request
`ifdef LB_BTN_LONG_PRESS_EN
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    nlong = 0;
    for (int i = 0; i < 20; i++) begin
      if (nlong == 0) begin
        step();
        if (interrupt && event_code == EV_LONG) nlong = 1;
      end
    end
    chk("held_reached", nlong, 32'd1);
`endif
    chk("pre_rst_int", {31'd0, interrupt}, 32'd1);
    reset = 1'b0;
    db = 1'b0;
    step();
    chk("mid_rst_outs", outs(), 32'd0);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (outs() != 32'd0) seen = 1'b1;
    end
    chk("post_rst_quiet", {31'd0, seen}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
